// File: rtl/axis_packet_arbiter_pkg.sv
// Shared stream-block definitions: arbiter state encoding and
// index helpers for flattened per-port buses.
package axis_packet_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/axis_packet_arbiter_rr_priority_select.sv
// Combinational round-robin search: first request at or above the
// pointer, wrapping modulo NUM_PORTS.
module rr_priority_select
  import axis_packet_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [SEL_WIDTH-1:0] i_ptr,
  output logic [SEL_WIDTH-1:0] o_idx,
  output logic                 o_any
);

  logic [SEL_WIDTH-1:0] w_k;

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_k   = '0;
    for (int d = 0; d < NUM_PORTS; d++) begin
      w_k = SEL_WIDTH'(wrap_add(int'(i_ptr), d, NUM_PORTS));
      if (!o_any && i_req[w_k]) begin
        o_any = 1'b1;
        o_idx = w_k;
      end
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-locked round-robin merge of NUM_PORTS streams into one
// registered output beat tagged with its source index.
module axis_packet_arbiter
  import axis_packet_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PORTS  = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] idata,
  input  logic [NUM_PORTS-1:0]            ivalid,
  input  logic [NUM_PORTS-1:0]            ilast,
  output logic [NUM_PORTS-1:0]            iready,
  output logic [DATA_WIDTH-1:0]           odata,
  output logic                            olast,
  output logic [SEL_WIDTH-1:0]            osel,
  output logic                            ovalid,
  input  logic                            oready
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;

  logic [SEL_WIDTH-1:0]  r_grant;
  logic [SEL_WIDTH-1:0]  r_ptr;
  logic [DATA_WIDTH-1:0] r_odata;
  logic                  r_olast;
  logic [SEL_WIDTH-1:0]  r_osel;
  logic                  r_ovalid;

  logic [SEL_WIDTH-1:0]  w_win;
  logic                  w_any;
  logic [DATA_WIDTH-1:0] w_gdata;
  logic                  w_gvalid;
  logic                  w_glast;
  logic                  w_free;
  logic                  w_xfer;
  logic [SEL_WIDTH-1:0]  w_ptr_nxt;

  rr_priority_select #(
    .NUM_PORTS (NUM_PORTS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_sel (
    .i_req (ivalid),
    .i_ptr (r_ptr),
    .o_idx (w_win),
    .o_any (w_any)
  );

  assign w_free    = !r_ovalid || oready;
  assign w_ptr_nxt = (r_grant == SEL_WIDTH'(NUM_PORTS - 1)) ?
                     '0 : r_grant + 1'b1;

  always_comb begin
    w_gdata  = '0;
    w_gvalid = 1'b0;
    w_glast  = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (r_grant == SEL_WIDTH'(k)) begin
        w_gdata  = idata[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH];
        w_gvalid = ivalid[k];
        w_glast  = ilast[k];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_any)
        r_grant <= w_win;
      if (w_xfer && w_glast)
        r_ptr <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_any) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_xfer && w_glast) w_state_nxt = ST_IDLE;
    endcase
  end

  // Lock holds through source gaps: ready follows the sink only.
  always_comb begin
    iready = '0;
    w_xfer = 1'b0;
    if (r_state == ST_BUSY) begin
      for (int k = 0; k < NUM_PORTS; k++)
        if (r_grant == SEL_WIDTH'(k))
          iready[k] = w_free;
      w_xfer = w_gvalid && w_free;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ovalid <= 1'b0;
      r_odata  <= '0;
      r_olast  <= 1'b0;
      r_osel   <= '0;
    end else if (w_xfer) begin
      r_ovalid <= 1'b1;
      r_odata  <= w_gdata;
      r_olast  <= w_glast;
      r_osel   <= r_grant;
    end else if (oready) begin
      r_ovalid <= 1'b0;
    end
  end

  assign odata  = r_odata;
  assign olast  = r_olast;
  assign osel   = r_osel;
  assign ovalid = r_ovalid;

endmodule

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

Round-robin, packet-aware arbiter that merges NUM_PORTS AXI-stream style sources into one output stream, normally the `idata`/`ivalid`/`iready` side of a stream FIFO. Once a source is granted, it keeps the grant until the beat carrying `ilast` is accepted, so packets are never interleaved. The output is a single registered stage, and the grant index travels with the data on `osel`.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one data beat
- NUM_PORTS, 4, number of requesters; legal range 2..2**SEL_WIDTH
- SEL_WIDTH, 2, width of the port index

Ports:
- clock  input  1  rising-edge clock for all state
- resetn  input  1  asynchronous, active-low reset
- idata  input  NUM_PORTS*DATA_WIDTH  concatenated beats; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- ivalid  input  NUM_PORTS  per-port beat valid
- ilast  input  NUM_PORTS  per-port end-of-packet flag, qualified by ivalid
- iready  output  NUM_PORTS  per-port accept; at most one bit high
- odata  output  DATA_WIDTH  registered output beat
- olast  output  1  registered end-of-packet flag
- osel  output  SEL_WIDTH  registered source index of the current output beat
- ovalid  output  1  output beat valid
- oready  input  1  sink accept

## Operation
- State machine has two states, IDLE and BUSY. Registers: `grant` (SEL_WIDTH), `pointer` (SEL_WIDTH), and the output stage.
- IDLE:
  - If any ivalid bit is set, pick the first set bit searching from `pointer` upward, wrapping modulo NUM_PORTS.
  - Register the winner into `grant` and move to BUSY.
  - All iready bits are 0.
- BUSY:
  - `iready[grant] = !ovalid || oready`; all other iready bits are 0.
  - A transfer occurs when `ivalid[grant] && iready[grant]`. On a transfer, the output stage loads idata slice, `ilast[grant]` and `grant`, and ovalid goes to 1.
  - If a transfer carries ilast, move to IDLE and set `pointer` to `grant+1`, wrapping NUM_PORTS-1 to 0.
- Output stage:
  - If there is no transfer and `oready` is high, ovalid goes to 0.
  - While `ovalid && !oready`, odata, olast and osel hold stable.
- Granted source deasserting ivalid mid-packet: the lock is held and the arbiter stalls. No other port is served.
- ivalid bits at indices ≥ NUM_PORTS do not exist. pointer and grant never exceed NUM_PORTS-1.
- Reset values (any time, including mid-packet):
  - State IDLE; grant 0; pointer 0.
  - ovalid 0, olast 0, odata 0, osel 0.
  - iready all 0.
  - A partially forwarded packet is abandoned. No recovery of the lost tail is attempted.

## Timing
- Arbitration bubble: ivalid seen in IDLE at cycle 0 gives grant at the cycle-1 edge and iready high during cycle 1, provided the output stage is free. The first beat has ovalid high in cycle 2.
- Steady state: one beat per cycle while the source is valid and oready is held high.
- Back-to-back packets from different ports: exactly one idle cycle between the last beat accepted and the next port's first iready.
- Every input-to-output path is registered. The only combinational paths are oready→iready and ivalid→next-grant.
- Simultaneous events:
  - A last-beat transfer and a new request in the same cycle: the new request is not arbitrated until the following IDLE cycle.
  - An output drain and an input load in the same cycle: the load wins and ovalid stays 1.

## Structure
- Shared package/header holds the state encoding (IDLE=0, BUSY=1) and the slice-index helper macro, shared with the other stream blocks.
- One sub-module, `rr_priority_select`, holds the combinational part.
  - Inputs: request vector and pointer.
  - Outputs: winner index and any-request flag.
  - It is tested standalone.
- The arbiter instance sits directly in front of the stream FIFO; its ovalid/oready connect to the FIFO's ivalid/iready.

## Test plan
- Reset with all ports valid, then release → in cycle 1 grant=0 and only iready[0] is high; in cycle 2 ovalid=1 and osel=0.
- All four ports send 1-beat packets (ilast=1) continuously with oready=1 → osel sequence 0,1,2,3,0,1, one idle cycle between beats, no port skipped.
- Port 2 sends a 3-beat packet (data A,B,C). Port 1 is valid throughout. oready is low during beat B for 2 cycles → odata holds B stable, olast=1 only on C, and port 1 is not granted until after C.
- Granted port 3 drops ivalid for 4 cycles mid-packet → no other iready rises, and the packet completes when port 3 resumes.
- resetn pulsed low while beat 2 of 4 is in the output stage → ovalid=0 immediately; after release, arbitration restarts from pointer 0.
- NUM_PORTS=3, SEL_WIDTH=2: only port 2 active, then ports 0 and 2 active → pointer wraps 2→0 and osel never equals 3.
